// File: rtl/button_event_gen_if.sv
// Button/event bus between the board-facing front-end and the menu consumers.
// The slave modport is the button_event_gen side. The master modport is the consumer/board side.
interface button_event_gen_if;
    logic [3:0] btn_n;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       ev_ack;
    logic       ev_overrun;

    modport slave (
        input  btn_n,
        input  ev_ack,
        output btn_level,
        output btn_press,
        output ev_valid,
        output ev_code,
        output ev_overrun
    );

    modport master (
        output btn_n,
        output ev_ack,
        input  btn_level,
        input  btn_press,
        input  ev_valid,
        input  ev_code,
        input  ev_overrun
    );
endinterface

// File: rtl/button_event_gen.sv
// Synchronise, debounce and edge-detect four active-low buttons, then latch one event for a
// valid/ack consumer. Optional AD/AT auto-repeat is enabled by defining AUTO_REPEAT_EN.
module button_event_gen #(
    parameter int unsigned DEB_CYCLES   = 48000,
    parameter int unsigned DEB_W        = 16,
    parameter int unsigned REPEAT_DELAY = 8000000,
    parameter int unsigned REPEAT_RATE  = 3200000,
    parameter int unsigned REP_W        = 24
) (
    input  logic               clk,
    input  logic               reset,
    button_event_gen_if.slave  bus
);

    localparam logic [DEB_W-1:0] DebMax = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic {StIdle, StHold} state_e;

    logic [3:0]       sync1_q, sync2_q, s;
    logic [DEB_W-1:0] cnt_q [4];
    logic [DEB_W-1:0] cnt_d [4];
    logic [3:0]       level_q, level_d, press_q, press_d, rise;
    state_e           state_q, state_d;
    logic [1:0]       code_q, code_d, win_code;
    logic             ovr_q, ovr_d, any_press, multi_press;

    always_comb begin
        s       = ~sync2_q;
        level_d = level_q;
        rise    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == DebMax) begin
                    level_d[i] = ~level_q[i];
                    rise[i]    = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [REP_W-1:0] RepDelayMax = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RepRateMax  = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_cnt_q [2];
    logic [REP_W-1:0] rep_cnt_d [2];
    logic [1:0]       rep_seen_q, rep_seen_d, rep_fire;

    // Counter runs only while the level stays high; a falling edge this cycle never fires.
    always_comb begin
        rep_fire   = 2'b00;
        rep_seen_d = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rep_cnt_d[i] = '0;
            if (level_q[i] && level_d[i]) begin
                if (rep_cnt_q[i] == (rep_seen_q[i] ? RepRateMax : RepDelayMax)) begin
                    rep_fire[i]   = 1'b1;
                    rep_seen_d[i] = 1'b1;
                end else begin
                    rep_cnt_d[i]  = rep_cnt_q[i] + 1'b1;
                    rep_seen_d[i] = rep_seen_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_q[0] <= '0;
            rep_cnt_q[1] <= '0;
            rep_seen_q   <= 2'b00;
        end else begin
            rep_cnt_q[0] <= rep_cnt_d[0];
            rep_cnt_q[1] <= rep_cnt_d[1];
            rep_seen_q   <= rep_seen_d;
        end
    end

    assign press_d = rise | {2'b00, rep_fire};
`else
    logic [REP_W-1:0] unused_rep_cfg;
    assign unused_rep_cfg = REP_W'(REPEAT_DELAY ^ REPEAT_RATE);
    assign press_d        = rise;
`endif

    always_comb begin
        any_press   = |press_q;
        multi_press = (press_q & (press_q - 4'd1)) != 4'd0;
        if (press_q[3])      win_code = 2'd3;
        else if (press_q[2]) win_code = 2'd2;
        else if (press_q[1]) win_code = 2'd1;
        else                 win_code = 2'd0;

        state_d = state_q;
        code_d  = code_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            StIdle: begin
                if (any_press) begin
                    state_d = StHold;
                    code_d  = win_code;
                    ovr_d   = ovr_q | multi_press;
                end
            end
            StHold: begin
                if (bus.ev_ack) begin
                    if (any_press) begin
                        code_d = win_code;
                        ovr_d  = multi_press;
                    end else begin
                        state_d = StIdle;
                        ovr_d   = 1'b0;
                    end
                end else if (any_press) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            level_q <= 4'b0000;
            press_q <= 4'b0000;
            state_q <= StIdle;
            code_q  <= 2'd0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= bus.btn_n;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            level_q <= level_d;
            press_q <= press_d;
            state_q <= state_d;
            code_q  <= code_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.btn_level  = level_q;
    assign bus.btn_press  = press_q;
    assign bus.ev_valid   = (state_q == StHold);
    assign bus.ev_code    = code_q;
    assign bus.ev_overrun = ovr_q;

endmodule
